// File: rtl/host_link_pkg.sv
// Shared encodings for the host link sequencer, the memory selector and the cores.
package host_link_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_LO,
    S_LOAD_HI,
    S_WRITE,
    S_RUN,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_LO,
    S_TX_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/byte_pack16.sv
// Little-endian byte-to-word packer: the low byte comes first, then the high byte.
module byte_pack16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [7:0]  byte_in,
  output logic [15:0] word_o,
  output logic        lo_held_o
);

  logic [15:0] word_q, word_d;
  logic        lo_held_q, lo_held_d;

  always_comb begin
    word_d    = word_q;
    lo_held_d = lo_held_q;
    if (clear) begin
      word_d    = '0;
      lo_held_d = 1'b0;
    end else if (load_lo) begin
      word_d[7:0] = byte_in;
      lo_held_d   = 1'b1;
    end else if (load_hi) begin
      word_d[15:8] = byte_in;
      lo_held_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      lo_held_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      lo_held_q <= lo_held_d;
    end
  end

  assign word_o    = word_q;
  assign lo_held_o = lo_held_q;

endmodule

// File: rtl/host_link_ctrl.sv
// Host link sequencer: loads words into data memory, runs the cores, streams results back.
//   state     | meaning
//   IDLE      | waiting for the first rx byte
//   LOAD_LO   | waiting for the low byte of the next word
//   LOAD_HI   | waiting for the high byte
//   WRITE     | one-cycle memory write of the assembled word
//   RUN       | cores released, waiting for end_process
//   RD_ADDR   | read address presented
//   RD_WAIT   | read data captured into hold register
//   TX_LO     | low byte offered to transmitter
//   TX_HI     | high byte offered to transmitter
//   DONE      | finished, parked until reset
module host_link_ctrl
  import host_link_pkg::*;
#(
  parameter int unsigned LOAD_WORDS   = 256,
  parameter logic [15:0] UNLOAD_BASE  = 16'h0000,
  parameter int unsigned UNLOAD_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        end_process,
  input  logic [15:0] com_data_out,
  output logic [1:0]  status,
  output logic [15:0] com_addr,
  output logic [15:0] com_data_in,
  output logic        com_wr_en,
  output logic        busy,
  output logic        done
);

  localparam logic [16:0] LOAD_N   = LOAD_WORDS[16:0];
  localparam logic [16:0] UNLOAD_N = UNLOAD_WORDS[16:0];

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] idx_q, idx_d;
  logic [15:0] hold_q, hold_d;
  logic        load_lo, load_hi, pack_clear, lo_held;
  logic [15:0] word;

  assign pack_clear = (state_q == S_RUN);

  byte_pack16 u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .load_lo   (load_lo),
    .load_hi   (load_hi),
    .byte_in   (rx_data),
    .word_o    (word),
    .lo_held_o (lo_held)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    load_lo = 1'b0;
    load_hi = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        load_lo = 1'b1;
        cnt_d   = '0;
        state_d = S_LOAD_HI;
      end
      S_LOAD_LO: if (rx_valid) begin
        load_lo = 1'b1;
        state_d = S_LOAD_HI;
      end
      S_LOAD_HI: if (rx_valid && lo_held) begin
        load_hi = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_d == LOAD_N) begin
          state_d = S_RUN;
        end else if (rx_valid) begin
          // byte arriving alongside the write is the next word's low half
          load_lo = 1'b1;
          state_d = S_LOAD_HI;
        end else begin
          state_d = S_LOAD_LO;
        end
      end
      S_RUN: if (end_process) begin
        idx_d   = '0;
        state_d = S_RD_ADDR;
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        hold_d  = com_data_out;
        state_d = S_TX_LO;
      end
      S_TX_LO: if (tx_ready) state_d = S_TX_HI;
      S_TX_HI: if (tx_ready) begin
        idx_d   = idx_q + 17'd1;
        state_d = (idx_d == UNLOAD_N) ? S_DONE : S_RD_ADDR;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status      = ST_IDLE;
    com_addr    = '0;
    com_data_in = '0;
    com_wr_en   = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE:              busy = 1'b0;
      S_LOAD_LO, S_LOAD_HI: status = ST_LOAD;
      S_WRITE: begin
        status      = ST_LOAD;
        com_wr_en   = 1'b1;
        com_addr    = cnt_q[15:0];
        com_data_in = word;
      end
      S_RUN:               status = ST_RUN;
      S_RD_ADDR, S_RD_WAIT: begin
        status   = ST_UNLOAD;
        com_addr = UNLOAD_BASE + idx_q[15:0];
      end
      S_TX_LO: begin
        status   = ST_UNLOAD;
        com_addr = UNLOAD_BASE + idx_q[15:0];
        tx_valid = 1'b1;
        tx_data  = hold_q[7:0];
      end
      S_TX_HI: begin
        status   = ST_UNLOAD;
        com_addr = UNLOAD_BASE + idx_q[15:0];
        tx_valid = 1'b1;
        tx_data  = hold_q[15:8];
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_host_link_ctrl.sv
// Directed bench for host_link_ctrl with a small synchronous data-memory model.
module tb_host_link_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        end_process;
  logic [15:0] com_data_out;
  logic [1:0]  status;
  logic [15:0] com_addr;
  logic [15:0] com_data_in;
  logic        com_wr_en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  host_link_ctrl #(
    .LOAD_WORDS   (2),
    .UNLOAD_BASE  (16'hFFFF),
    .UNLOAD_WORDS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .end_process  (end_process),
    .com_data_out (com_data_out),
    .status       (status),
    .com_addr     (com_addr),
    .com_data_in  (com_data_in),
    .com_wr_en    (com_wr_en),
    .busy         (busy),
    .done         (done)
  );

  // Address 0xFFFF reads back a fixed pattern; everything else is plain RAM.
  always_ff @(posedge clk) begin
    if (com_wr_en) mem[com_addr] <= com_data_in;
    com_data_out <= (com_addr == 16'hFFFF) ? 16'hBEEF : mem[com_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    tx_ready = 1'b0; end_process = 1'b0;
    tick(); tick();
    chk("rst_status", status, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_wr", com_wr_en, 1'b0);
    chk("rst_addr", com_addr, 16'h0000);
    chk("rst_din", com_data_in, 16'h0000);

    // reset after a lone low byte
    rst_n = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    chk("half_status", status, 2'd1);
    chk("half_busy", busy, 1'b1);
    rx_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("midrst_status", status, 2'd0);
    chk("midrst_wr", com_wr_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // back-to-back load of two words
    rx_valid = 1'b1; rx_data = 8'h34;
    tick();
    chk("ld_status", status, 2'd1);
    chk("ld_wr0_idle", com_wr_en, 1'b0);
    rx_data = 8'h12;
    tick();
    chk("wr0_en", com_wr_en, 1'b1);
    chk("wr0_addr", com_addr, 16'h0000);
    chk("wr0_data", com_data_in, 16'h1234);
    rx_data = 8'h78;
    tick();
    chk("gap_wr", com_wr_en, 1'b0);
    rx_data = 8'h56;
    tick();
    chk("wr1_en", com_wr_en, 1'b1);
    chk("wr1_addr", com_addr, 16'h0001);
    chk("wr1_data", com_data_in, 16'h5678);
    rx_data = 8'h99;
    tick();
    chk("run_status", status, 2'd2);
    chk("run_wr", com_wr_en, 1'b0);

    // stray bytes while running
    for (int i = 0; i < 9; i++) begin
      rx_valid = (i < 4); rx_data = 8'(8'hC0 + i);
      tick();
      chk("run_stray_wr", com_wr_en, 1'b0);
      chk("run_stray_st", status, 2'd2);
    end
    rx_valid = 1'b0;
    end_process = 1'b1;
    tick();
    chk("rd0_status", status, 2'd3);
    chk("rd0_addr", com_addr, 16'hFFFF);
    chk("rd0_txv", tx_valid, 1'b0);
    end_process = 1'b0;
    tick();
    chk("rw0_txv", tx_valid, 1'b0);
    tick();
    chk("tx0_lo_v", tx_valid, 1'b1);
    chk("tx0_lo_d", tx_data, 8'hEF);

    // transmitter stalls on the low byte
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_v", tx_valid, 1'b1);
      chk("stall_d", tx_data, 8'hEF);
      chk("stall_addr", com_addr, 16'hFFFF);
    end
    tx_ready = 1'b1;
    tick();
    chk("tx0_hi_v", tx_valid, 1'b1);
    chk("tx0_hi_d", tx_data, 8'hBE);
    tick();
    chk("rd1_addr", com_addr, 16'h0000);
    chk("rd1_txv", tx_valid, 1'b0);
    chk("rd1_status", status, 2'd3);
    tick();
    chk("rw1_txv", tx_valid, 1'b0);
    tick();
    chk("tx1_lo_v", tx_valid, 1'b1);
    chk("tx1_lo_d", tx_data, 8'h34);
    tick();
    chk("tx1_hi_d", tx_data, 8'h12);
    tick();
    chk("done", done, 1'b1);
    chk("done_status", status, 2'd0);
    chk("done_busy", busy, 1'b0);
    chk("done_txv", tx_valid, 1'b0);

    // stray bytes after completion
    rx_valid = 1'b1; rx_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_stray_wr", com_wr_en, 1'b0);
      chk("done_stray_dn", done, 1'b1);
    end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("final_rst_done", done, 1'b0);
    chk("final_rst_st", status, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_link_ctrl.md
Name: host_link_ctrl

Overview:
Host-side sequencer sitting directly upstream of the multi-core top level. It drives that level's status, com_addr, com_data_in and com_wr_en inputs, and consumes its com_data_out and end_process outputs. It assembles a UART-style byte stream into 16-bit words and writes them into shared data memory. It then releases the cores, waits for end_process, and streams a result window of data memory back out as bytes.

Parameters:
LOAD_WORDS, 256, number of 16-bit words loaded into data memory starting at address 0 (1..65536)
UNLOAD_BASE, 0, first data-memory address returned to the host
UNLOAD_WORDS, 256, number of 16-bit words returned to the host (1..65536)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
rx_data  in  8  received byte from host link
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
tx_data  out  8  byte to host link
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
end_process  in  1  core 0 finished execution (level)
com_data_out  in  16  data-memory read data, valid 1 cycle after com_addr is presented
status  out  2  system mode to cores and memory selector
com_addr  out  16  data-memory address
com_data_in  out  16  data-memory write data
com_wr_en  out  1  data-memory write strobe, one cycle per word
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE, status=ST_IDLE, com_addr=0, com_data_in=0, com_wr_en=0, tx_valid=0, tx_data=0, busy=0, done=0, internal counters=0.
- Reset mid-operation: returns to IDLE on the next edge regardless of state. Any partially assembled word is discarded. A pending tx byte is dropped (tx_valid=0).
- Status encoding: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2, ST_UNLOAD=2'd3.
- Word assembly: little-endian; the first byte is bits [7:0], the second byte is bits [15:8].
- FSM states and transitions:
  - IDLE: status=ST_IDLE. rx_valid latches the byte as the low half and moves to LOAD_HI with status=ST_LOAD.
  - LOAD_LO: wait for rx_valid; latch the low byte; go to LOAD_HI.
  - LOAD_HI: wait for rx_valid; form the word; go to WRITE.
  - WRITE: single cycle. com_wr_en=1, com_addr=word count, com_data_in=assembled word. Increment the count.
    - If the count reaches LOAD_WORDS, go to RUN.
    - Otherwise go to LOAD_LO.
  - Back-to-back rx_valid: rx_valid arriving during WRITE is accepted as the next low byte. WRITE then proceeds directly to LOAD_HI, so no byte is lost at one byte per cycle.
  - RUN: status=ST_RUN, com_wr_en=0. rx bytes are ignored. When end_process=1 is sampled, go to RD_ADDR with status=ST_UNLOAD and read index=0.
  - RD_ADDR: com_addr = UNLOAD_BASE + index (16-bit wrap-around past 0xFFFF). Go to RD_WAIT.
  - RD_WAIT: capture com_data_out into a 16-bit holding register. Go to TX_LO.
  - TX_LO: tx_valid=1, tx_data=hold[7:0]. On tx_ready, go to TX_HI.
  - TX_HI: tx_valid=1, tx_data=hold[15:8]. On tx_ready, increment the index.
    - If the index reaches UNLOAD_WORDS, go to DONE.
    - Otherwise go to RD_ADDR.
  - DONE: status=ST_IDLE, done=1, tx_valid=0. Remains here until reset.
- tx handshake: tx_data and tx_valid are stable while tx_valid && !tx_ready. tx_valid never drops without acceptance, except on reset.
- rx bytes are ignored in RUN, all unload states and DONE.
- end_process already high on entry to RUN: the FSM leaves RUN after exactly one cycle in RUN.
- Counters are 17 bits so a count of 65536 is representable.
- com_wr_en is never asserted outside WRITE.
- Round-trip latency per unloaded word, with tx_ready tied high: 4 cycles.

Decomposition:
- Shared package host_link_pkg holds the status encodings ST_IDLE, ST_LOAD, ST_RUN and ST_UNLOAD. The selector and cores use the same package.
- The FSM state enum lives in host_link_pkg.
- One sub-module: byte_pack16. It holds the low/high byte phase flag and the word register, with load_lo, load_hi and clear inputs. Packing logic stays out of the FSM.

Test Plan:
1. LOAD_WORDS=2; bytes 34,12,78,56 at one per cycle -> writes of 0x1234@0 then 0x5678@1, one cycle each; status goes 1 then 2.
2. In RUN, assert end_process at cycle 10; com_data_out=0xBEEF; UNLOAD_WORDS=1; tx_ready=1 -> tx bytes EF then BE; done=1; status=0.
3. tx_ready low for 5 cycles during TX_LO -> tx_valid=1 and tx_data=0xEF held stable throughout; no extra com_addr issued.
4. UNLOAD_BASE=0xFFFF, UNLOAD_WORDS=2 -> com_addr sequence 0xFFFF then 0x0000.
5. rst_n=0 for one cycle after the first of two bytes of a word -> IDLE, no com_wr_en; the next load starts fresh at address 0.
6. Stray rx_valid bytes during RUN and DONE -> no com_wr_en pulses and no state change.
